serial_rx_writer: RTL
=====================

Name: serial_rx_writer

Overview:
UART-style serial receiver that deserializes 8N1 frames from an asynchronous rx line. It writes each completed byte into the downstream 16x8 FIFO through that FIFO's wr/din/full interface. It sits directly upstream of the FIFO and is its only writer. The FIFO gives write priority over read, so every wr issued while full is low is accepted in that cycle.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 4; half-bit point = CLKS_PER_BIT/2 (floor)
PARITY_ODD, 0, parity sense when SERIAL_RX_PARITY_EN is defined; 0 = even, 1 = odd; ignored otherwise

Ports:
clk  input  1  single clock; all logic on posedge clk
rst  input  1  reset, asynchronous, active-high
rx  input  1  asynchronous serial line; idle high
fifo_full  input  1  FIFO full flag
wr  output  1  FIFO write strobe; one-cycle pulse per accepted byte
din  output  8  byte to FIFO; registered; valid when wr=1, holds last byte otherwise
frame_err  output  1  one-cycle pulse; stop bit sampled low
overrun  output  1  one-cycle pulse; byte completed while fifo_full=1, byte dropped
parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when macro undefined

Behaviour:
- rx passes through a 2-flop synchronizer (rx_s); both flops reset to 1. Only rx_s is used internally.
- Reset (async, any state): state=IDLE, bit counter=0, clock-tick counter=0, shift register=0, din=0, wr=0, frame_err=0, overrun=0, parity_err=0.
- Tick counter width is $clog2(CLKS_PER_BIT). A "tick" is the counter reaching its terminal value; the counter then reloads to 0.
- FSM states:
  - IDLE: rx_s==0 -> START, counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s. 0 -> DATA (bit index 0). 1 -> IDLE (glitch rejected, no output).
  - DATA: sample rx_s every CLKS_PER_BIT cycles, LSB first, into the shift register. After bit 7 -> STOP (or PARITY when the macro is defined).
  - STOP: after CLKS_PER_BIT cycles, sample rx_s. 1 -> PUSH. 0 -> frame_err=1 for 1 cycle, then BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE. Prevents a held-low line from being decoded as 0x00 frames.
  - PUSH: exactly one cycle. If fifo_full==0: wr=1, din=shift register. Else: overrun=1, wr=0, din unchanged. Always -> IDLE.
- Latency: wr asserts the cycle after the stop-bit sample. Start edge on rx to wr is about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.
- fifo_full is sampled only in PUSH. Its value during the rest of the frame is irrelevant.
- Back-to-back frames: IDLE is entered with rx_s high (stop bit), so the next start edge is detected in the first IDLE cycle. No frames are lost at the full line rate.
- wr never asserts for two consecutive cycles. frame_err, overrun and parity_err are mutually exclusive per frame.

Optional Feature:
SERIAL_RX_PARITY_EN
- Defined: PARITY state between DATA and STOP samples one extra bit after CLKS_PER_BIT cycles. It compares the bit to XOR(data)^PARITY_ODD.
  - Mismatch: parity_err pulses in the cycle following the STOP sample, no wr, -> IDLE. This applies only if the stop bit is 1; a stop bit of 0 takes the frame_err path.
  - Match: normal STOP/PUSH flow.
- Undefined: no PARITY state, parity_err tied to 0, 8N1 framing only.

Decomposition:
- Package serial_rx_pkg: state enum typedef (IDLE, START, DATA, PARITY, STOP, BREAK, PUSH), DATA_W=8 constant, RX_IDLE=1'b1 constant.
- Sub-module sync_2ff: 2-flop synchronizer with reset value parameter.
- The FSM, counters and shift register stay in serial_rx_writer.

Test Plan:
- CLKS_PER_BIT=16, send 8N1 0xA5, fifo_full=0 -> exactly one wr pulse with din=0xA5; frame_err, overrun and parity_err stay 0.
- rx low for 4 cycles then high -> START rejects it; no wr, no error pulses, state returns to IDLE.
- Send 0x3C with the stop bit held low for 20 bit times -> one frame_err pulse, no wr. No further frames decoded until rx rises; the next frame 0x11 yields wr with din=0x11.
- fifo_full=1 and send 0x55 -> one overrun pulse, wr=0, din keeps its previous value. Then fifo_full=0 and send 0x66 -> wr with din=0x66.
- 16 back-to-back frames 0x00..0x0F with no idle gap -> 16 wr pulses in order, din matching each byte.
- Assert rst during data bit 3 of a frame -> all outputs 0 immediately (async). After release, send 0x81 -> wr with din=0x81.
- With SERIAL_RX_PARITY_EN defined, send 0x07 with a wrong even-parity bit -> one parity_err pulse, no wr.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial receiver / FIFO writer.
package serial_rx_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam logic        RX_IDLE = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak,
        StPush
    } rx_state_e;

    // Expected parity bit for a data byte; odd_sense selects odd parity.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd_sense);
        return (^data) ^ odd_sense;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; both come out of reset at RESET_VAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/serial_rx_writer.sv
// 8N1 serial receiver that writes each completed byte into a downstream FIFO.
// Optional parity bit between data and stop: define SERIAL_RX_PARITY_EN.
module serial_rx_writer
    import serial_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic        PARITY_ODD   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              fifo_full,
    output logic              wr,
    output logic [DATA_W-1:0] din,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW = $clog2(DATA_W);

    localparam logic [CntW-1:0] HalfTerm = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullTerm = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] LastBit  = BitW'(DATA_W - 1);

    logic rx_s;

    rx_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;

    logic              wr_q, wr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic tick_half;
    logic tick_full;
    logic par_bad;

    sync_2ff #(
        .RESET_VAL (RX_IDLE)
    ) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign tick_half = (cnt_q == HalfTerm);
    assign tick_full = (cnt_q == FullTerm);

`ifdef SERIAL_RX_PARITY_EN
    logic par_q, par_d;
    logic parity_err_q, parity_err_d;

    assign par_bad = (par_q != parity_bit(shift_q, PARITY_ODD));

    // Capture the received parity bit at its mid-bit sample.
    always_comb begin
        par_d = par_q;
        if (state_q == StParity && tick_full) begin
            par_d = rx_s;
        end
    end

    // Parity error only when the stop bit itself is good.
    always_comb begin
        parity_err_d = (state_q == StStop) && tick_full && (rx_s == RX_IDLE) && par_bad;
    end

    // Parity bit and parity error pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, tick counter, bit index and shift register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
                if (rx_s != RX_IDLE) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick_half) begin
                    cnt_d = '0;
                    // Still low at mid start bit: a real frame, otherwise a glitch.
                    if (rx_s != RX_IDLE) begin
                        state_d = StData;
                        bit_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (tick_full) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    if (bit_q == LastBit) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                if (tick_full) begin
                    cnt_d   = '0;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick_full) begin
                    cnt_d = '0;
                    if (rx_s != RX_IDLE) begin
                        state_d = StBreak;
                    end else if (par_bad) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StPush;
                    end
                end
            end
            StBreak: begin
                // Held-low line: wait for idle so it is not decoded as 0x00 frames.
                cnt_d = '0;
                if (rx_s == RX_IDLE) begin
                    state_d = StIdle;
                end
            end
            StPush: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Output next values: write or overrun decided in PUSH, frame error at the stop sample.
    always_comb begin
        wr_d        = (state_q == StPush) && !fifo_full;
        overrun_d   = (state_q == StPush) && fifo_full;
        din_d       = wr_d ? shift_q : din_q;
        frame_err_d = (state_q == StStop) && tick_full && (rx_s != RX_IDLE);
    end

    // Datapath and registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            wr_q        <= 1'b0;
            din_q       <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wr_q        <= wr_d;
            din_q       <= din_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign wr        = wr_q;
    assign din       = din_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
